mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single unified memory port between instruction fetch (IF) and load/store (LS).
//  Sits between the cpu core's fetch/data interfaces and the memory model.
//  Allows one outstanding transaction. Steers each response back to the requester that issued it.
//  Stalls the loser through its grant signal.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  STARVE_MAX  4   LS grants in a row, while IF waits, before IF is forced (needs ARB_STARVE_GUARD_EN)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  if_req      in   1      fetch request; held stable until if_gnt
//  if_addr     in   AW     fetch address
//  if_gnt      out  1      fetch request accepted this cycle
//  if_rvalid   out  1      fetch data valid, 1-cycle pulse
//  if_rdata    out  DW     fetch data
//  ls_req      in   1      load/store request; held stable until ls_gnt
//  ls_we       in   1      1 = store
//  ls_addr     in   AW     data address
//  ls_wdata    in   DW     store data
//  ls_wstrb    in   DW/8   byte strobes
//  ls_gnt      out  1      LS request accepted this cycle
//  ls_rvalid   out  1      load data / store ack, 1-cycle pulse
//  ls_rdata    out  DW     load data (undefined on store ack)
//  mem_valid   out  1      request to memory
//  mem_ready   in   1      memory accepts request
//  mem_we, mem_addr, mem_wdata, mem_wstrb   out   request fields muxed from the winner
//  mem_rvalid  in   1      response/ack strobe, 1 cycle
//  mem_rdata   in   DW     response data
// BEHAVIOUR
//  States: IDLE, WAIT_IF, WAIT_LS. Encoded 2-bit.
//  Reset state is IDLE. Reset values: all outputs and starve_cnt = 0.
//  IDLE:
//   - mem_valid = if_req|ls_req, combinational.
//   - Winner's fields are muxed onto mem_*.
//   - Winner's gnt = mem_ready.
//   - On handshake, go to WAIT_IF or WAIT_LS.
//  Priority: LS beats IF when both request.
//  WAIT_x:
//   - mem_valid=0 and both gnt=0.
//   - On mem_rvalid, raise x_rvalid the same cycle, drive x_rdata=mem_rdata, and return to IDLE.
//  Stores also wait for mem_rvalid as the ack.
//  Minimum cost: 2 cycles per access (grant, then response). The next grant comes no earlier than the cycle after rvalid.
//  mem_rvalid in IDLE is ignored and produces no rvalid pulse.
//  Zero-wait memory case: mem_ready=1 and mem_rvalid the next cycle gives 1 transaction per 2 cycles.
//  If mem_ready is held low, the winner's request stays on mem_* unchanged. Selection is recomputed each cycle.
//   - A newly arriving LS request may overtake a pending IF request.
//  Async reset mid-WAIT: return to IDLE and drop the response. Memory must be reset on the same signal.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - starve_cnt (width $clog2(STARVE_MAX+1)) counts LS grants made while if_req=1.
//   - When starve_cnt==STARVE_MAX, the next IDLE handshake goes to IF even if ls_req=1.
//   - starve_cnt clears on any IF grant, and whenever if_req=0 in IDLE.
//  ARB_STARVE_GUARD_EN undefined: strict LS priority, and no counter is instantiated.
// STRUCTURE
//  Shared package cpu_mem_pkg: state enum/localparams (IDLE=0, WAIT_IF=1, WAIT_LS=2), AW/DW defaults, strobe width.
//  Single module. No sub-module: the FSM, the request mux and the optional counter stay inline.
// TESTING
//  1. Single fetch: if_req at 0x0000_0010, mem_ready=1, rvalid 1 cycle later with 0x0050_0093
//     -> if_gnt for 1 cycle, then if_rvalid with if_rdata=0x0050_0093, no ls_rvalid.
//  2. Collision: if_req and ls_req in the same cycle, load 0x100
//     -> ls_gnt first, mem_addr=0x100; if_gnt only after ls_rvalid plus 1 cycle.
//  3. Store: ls_we=1, addr 0x200, wdata 0xDEAD_BEEF, wstrb 0xF
//     -> mem_we=1 with the same fields; ls_rvalid on the ack; if_rvalid stays 0.
//  4. Backpressure: mem_ready=0 for 3 cycles
//     -> mem_valid=1 and mem_addr stable, no gnt; gnt in the cycle mem_ready=1.
//  5. Starvation (macro on, STARVE_MAX=4): ls_req and if_req both held
//     -> 4 LS grants, then 1 IF grant, then LS again.
//     Macro off -> IF never granted while ls_req is held.
//  6. Reset pulled low in WAIT_LS, before rvalid
//     -> all outputs 0 immediately; after release, a stale mem_rvalid gives no ls_rvalid.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified memory-port arbiter:
// FSM state encoding and default bus widths.
package cpu_mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int SW_DEF = DW_DEF / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LS.
// Define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX LS wins.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wstrb,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    arb_state_e r_state;
    logic       w_idle;
    logic       w_pick_ls;
    logic       w_force_if;
    logic       w_ls_sel;

    // Outputs are gated by reset so they drop the instant reset asserts.
    assign w_idle    = reset && (r_state == IDLE);
    assign w_pick_ls = ls_req && !w_force_if;
    assign mem_valid = w_idle && (if_req || ls_req);
    assign w_ls_sel  = mem_valid && w_pick_ls;

    assign mem_we    = w_ls_sel && ls_we;
    assign mem_addr  = !mem_valid ? '0 : (w_pick_ls ? ls_addr : if_addr);
    assign mem_wdata = w_ls_sel ? ls_wdata : '0;
    assign mem_wstrb = w_ls_sel ? ls_wstrb : '0;

    assign ls_gnt = w_ls_sel && mem_ready;
    assign if_gnt = mem_valid && !w_pick_ls && mem_ready;

    assign if_rvalid = reset && (r_state == WAIT_IF) && mem_rvalid;
    assign ls_rvalid = reset && (r_state == WAIT_LS) && mem_rvalid;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_starve_cnt;

    assign w_force_if = if_req && (r_starve_cnt == CW'(STARVE_MAX));

    // An LS grant with if_req high implies the count is below the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (if_gnt || !if_req) begin
                r_starve_cnt <= '0;
            end else if (ls_gnt) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (ls_gnt) begin
                        r_state <= WAIT_LS;
                    end else if (if_gnt) begin
                        r_state <= WAIT_IF;
                    end
                end
                WAIT_IF, WAIT_LS: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed checks of mem_port_arbiter against a
// transaction-level model of the shared memory port.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic [SW-1:0] ls_wstrb = '0;
    logic          ls_gnt, ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_valid, mem_we;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int ncmp  = 0;
    int nfail = 0;

    // Model: is a transaction outstanding, who owns it, LS wins in a row.
    bit m_busy   = 1'b0;
    bit m_own_ls = 1'b0;
    int m_scnt   = 0;
    bit e_if_gnt = 1'b0;
    bit e_ls_gnt = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic settle();
        bit any;
        bit ls_win;
        #2;
        if (!reset) begin
            m_busy = 1'b0;
            m_scnt = 0;
            e_if_gnt = 1'b0;
            e_ls_gnt = 1'b0;
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_ls_gnt", ls_gnt, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_ls_rvalid", ls_rvalid, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_ls_rdata", ls_rdata, 0);
        end else if (!m_busy) begin
            any = if_req || ls_req;
            ls_win = ls_req && !(GUARD && if_req && m_scnt >= SMAX);
            e_ls_gnt = ls_win && mem_ready;
            e_if_gnt = any && !ls_win && mem_ready;
            chk("mem_valid", mem_valid, 32'(any));
            chk("if_gnt", if_gnt, 32'(e_if_gnt));
            chk("ls_gnt", ls_gnt, 32'(e_ls_gnt));
            chk("idle_if_rvalid", if_rvalid, 0);
            chk("idle_ls_rvalid", ls_rvalid, 0);
            if (any) begin
                chk("mem_addr", mem_addr, ls_win ? ls_addr : if_addr);
                chk("mem_we", mem_we, 32'(ls_win && ls_we));
            end
            if (ls_win && ls_we) begin
                chk("mem_wdata", mem_wdata, ls_wdata);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(ls_wstrb));
            end
        end else begin
            e_if_gnt = 1'b0;
            e_ls_gnt = 1'b0;
            chk("wait_mem_valid", mem_valid, 0);
            chk("wait_if_gnt", if_gnt, 0);
            chk("wait_ls_gnt", ls_gnt, 0);
            chk("if_rvalid", if_rvalid, 32'(mem_rvalid && !m_own_ls));
            chk("ls_rvalid", ls_rvalid, 32'(mem_rvalid && m_own_ls));
            if (mem_rvalid && m_own_ls) chk("ls_rdata", ls_rdata, mem_rdata);
            if (mem_rvalid && !m_own_ls) chk("if_rdata", if_rdata, mem_rdata);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (reset) begin
            if (!m_busy) begin
                if (e_if_gnt || !if_req) m_scnt = 0;
                else if (e_ls_gnt) m_scnt++;
                if (e_if_gnt || e_ls_gnt) begin
                    m_busy = 1'b1;
                    m_own_ls = e_ls_gnt;
                end
            end else if (mem_rvalid) begin
                m_busy = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic clr();
        if_req = 0; ls_req = 0; ls_we = 0; mem_ready = 1; mem_rvalid = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    endtask

    initial begin
        bit pend = 1'b0;
        int rvc = 0;
        bit g_if, g_ls;
        bit exp_if;

        @(negedge clk);
        settle();
        chk("reset_if_gnt", if_gnt, 0);
        adv();
        reset = 1'b1;
        clr();

        // single fetch
        if_req = 1; if_addr = 32'h0000_0010;
        settle();
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_addr", mem_addr, 32'h10);
        adv();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        settle();
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 32'h0050_0093);
        chk("t1_ls_rvalid", ls_rvalid, 0);
        adv();
        mem_rvalid = 0;

        // collision: LS load wins, IF waits until after the response
        if_req = 1; if_addr = 32'h20;
        ls_req = 1; ls_addr = 32'h100;
        settle();
        chk("t2_ls_gnt", ls_gnt, 1);
        chk("t2_if_gnt", if_gnt, 0);
        chk("t2_addr", mem_addr, 32'h100);
        adv();
        ls_req = 0;
        settle();
        chk("t2_wait_if_gnt", if_gnt, 0);
        adv();
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        settle();
        chk("t2_ls_rvalid", ls_rvalid, 1);
        chk("t2_rv_if_gnt", if_gnt, 0);
        adv();
        mem_rvalid = 0;
        settle();
        chk("t2_if_gnt_late", if_gnt, 1);
        chk("t2_if_addr", mem_addr, 32'h20);
        adv();
        if_req = 0; mem_rvalid = 1;
        settle();
        adv();
        mem_rvalid = 0;

        // store
        ls_req = 1; ls_we = 1; ls_addr = 32'h200;
        ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'hF;
        settle();
        chk("t3_ls_gnt", ls_gnt, 1);
        chk("t3_we", mem_we, 1);
        chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_wstrb", 32'(mem_wstrb), 32'hF);
        adv();
        ls_req = 0; ls_we = 0; mem_rvalid = 1;
        settle();
        chk("t3_ls_rvalid", ls_rvalid, 1);
        chk("t3_if_rvalid", if_rvalid, 0);
        adv();
        mem_rvalid = 0;

        // backpressure
        if_req = 1; if_addr = 32'h40; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t4_valid", mem_valid, 1);
            chk("t4_addr", mem_addr, 32'h40);
            chk("t4_no_gnt", if_gnt, 0);
            adv();
        end
        mem_ready = 1;
        settle();
        chk("t4_gnt", if_gnt, 1);
        adv();
        if_req = 0; mem_rvalid = 1;
        settle();
        adv();
        mem_rvalid = 0;

        // starvation: both held continuously
        if_req = 1; if_addr = 32'h80;
        ls_req = 1; ls_addr = 32'h180;
        for (int k = 0; k < 10; k++) begin
            exp_if = GUARD && (k % 5 == 4);
            settle();
            chk("t5_if_gnt", if_gnt, 32'(exp_if));
            chk("t5_ls_gnt", ls_gnt, 32'(!exp_if));
            adv();
            mem_rvalid = 1;
            settle();
            adv();
            mem_rvalid = 0;
        end
        clr();
        settle();
        adv();

        // reset while waiting on an LS response
        ls_req = 1; ls_addr = 32'h300;
        settle();
        chk("t6_ls_gnt", ls_gnt, 1);
        adv();
        ls_req = 0;
        settle();
        adv();
        reset = 0; if_req = 1; ls_req = 1;
        settle();
        chk("t6_rst_valid", mem_valid, 0);
        chk("t6_rst_ls_gnt", ls_gnt, 0);
        adv();
        reset = 1; if_req = 0; ls_req = 0; mem_rvalid = 1;
        settle();
        chk("t6_stale_ls_rvalid", ls_rvalid, 0);
        adv();
        mem_rvalid = 0;

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (!if_req && $urandom % 3 == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_req && $urandom % 3 == 0) begin
                ls_req = 1; ls_we = 1'($urandom); ls_addr = $urandom;
                ls_wdata = $urandom; ls_wstrb = 4'($urandom);
            end
            mem_ready = ($urandom % 4) != 0;
            mem_rdata = $urandom;
            mem_rvalid = 0;
            if (pend) begin
                if (rvc == 0) begin
                    mem_rvalid = 1; pend = 0;
                end else begin
                    rvc--;
                end
            end else if ($urandom % 8 == 0) begin
                mem_rvalid = 1;
            end
            reset = ($urandom % 400) != 0;
            if (!reset) begin
                pend = 0; mem_rvalid = 0;
            end
            settle();
            g_if = e_if_gnt;
            g_ls = e_ls_gnt;
            adv();
            if (g_if) if_req = 0;
            if (g_ls) ls_req = 0;
            if (g_if || g_ls) begin
                pend = 1; rvc = $urandom_range(0, 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
